// File: rtl/sinh_stage_arbiter.sv
// Round-robin arbiter sharing one stage-2 sinh shift-add unit among NREQ requesters.
// Latency: grant cycle, one EXEC cycle, then the result is held in HOLD; accepts are at least 3 cycles apart.
// Backpressure: HOLD persists while out_ready=0 and no req_ready is raised until the result pops.
module sinh_stage_arbiter #(
    parameter int DWIDTH = 16,
    parameter int NREQ   = 4,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    input  logic [NREQ-1:0]        req_scomp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DWIDTH-1:0]      out_data,
    output logic [IDW-1:0]         out_id,
    output logic                   busy,
    output logic [15:0]            done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [DWIDTH-1:0] op;
        logic              sc;
        logic [IDW-1:0]    id;
    } slot_t;

    state_t                    state, state_nxt;
    slot_t                     slot;
    logic [IDW-1:0]            rr_ptr;
    logic [IDW-1:0]            gnt_id;
    logic                      gnt_any;
    logic                      accept;
    int                        idx;
    logic signed [DWIDTH-1:0]  unit_x, unit_sum;
    logic [DWIDTH-1:0]         unit_out;

    // Rotating-priority search: first valid index at or after rr_ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

    assign accept = (state == IDLE) && gnt_any;

    always_comb begin
        req_ready = '0;
        if (accept && rstn) req_ready[gnt_id] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_any) state_nxt = EXEC;
            EXEC:    state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Shared s2sinh unit; sums wrap at DWIDTH bits by construction.
    always_comb begin
        unit_x   = $signed(slot.op);
        unit_sum = '0;
        unit_out = '0;
        if (slot.sc) begin
            unit_sum = unit_x + (unit_x >>> 4);
            unit_out = unit_sum >>> 9;
        end else begin
            unit_sum = unit_x + (unit_x >>> 9);
            unit_out = unit_sum >>> 3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot      <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            busy      <= 1'b0;
            done_cnt  <= '0;
        end else begin
            busy      <= (state_nxt != IDLE);
            out_valid <= (state_nxt == HOLD);
            if (accept) begin
                slot   <= '{op: req_data[gnt_id*DWIDTH +: DWIDTH], sc: req_scomp[gnt_id], id: gnt_id};
                rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            if (state == EXEC) begin
                out_data <= unit_out;
                out_id   <= slot.id;
            end
            if (state == HOLD && out_ready) done_cnt <= done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sinh_stage_arbiter.sv
// Directed plus randomized checks of sinh_stage_arbiter against an arithmetic/queue-free reference.
module tb_sinh_stage_arbiter;
    localparam int DW  = 16;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*DW-1:0]  req_data = '0;
    logic [N-1:0]     req_scomp = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_data;
    logic [IDW-1:0]   out_id;
    logic             busy;
    logic [15:0]      done_cnt;

    int passed = 0;
    int total = 0;
    int ptr = 0;
    int done_exp = 0;
    int cyc = 0;
    int last_acc = -1;

    sinh_stage_arbiter #(.DWIDTH(DW), .NREQ(N)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_scomp(req_scomp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id),
        .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int fdiv(int a, int d);
        int q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // x*(1+2^-a)*2^-b with floor rounding, intermediate sum wrapped to 16-bit signed.
    function automatic logic [15:0] ref_sinh(logic [15:0] x, logic sc);
        int xi, t, r;
        xi = int'($signed(x));
        t  = xi + fdiv(xi, sc ? 16 : 512);
        t  = ((t % 65536) + 65536) % 65536;
        if (t >= 32768) t = t - 65536;
        r  = fdiv(t, sc ? 512 : 8);
        return 16'(r);
    endfunction

    function automatic int exp_grant(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(int i, logic [15:0] x, logic sc);
        req_data[i*DW +: DW] = x;
        req_scomp[i] = sc;
    endtask

    task automatic do_reset(logic [N-1:0] v);
        rstn = 1'b0;
        req_valid = v;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done_cnt), 0);
        rstn = 1'b1;
        #1;
        ptr = 0;
        done_exp = 0;
        last_acc = -1;
    endtask

    // Starts in an IDLE cycle and returns in the next IDLE cycle.
    task automatic txn(logic [N-1:0] v, int holdoff, bit keep, int spacing);
        int g;
        logic [15:0] ed;
        req_valid = v;
        #1;
        g = exp_grant(v, ptr);
        if (g < 0) begin
            chk("idle_no_ready", 32'(req_ready), 0);
            tick();
            return;
        end
        chk("grant", 32'(req_ready), 32'(1 << g));
        ed = ref_sinh(req_data[g*DW +: DW], req_scomp[g]);
        if (spacing > 0 && last_acc >= 0) chk("spacing", 32'(cyc - last_acc), 32'(spacing));
        last_acc = cyc;
        ptr = (g + 1) % N;
        tick();
        if (!keep) req_valid = '0;
        #1;
        chk("exec_busy", 32'(busy), 1);
        chk("exec_valid", 32'(out_valid), 0);
        chk("exec_ready", 32'(req_ready), 0);
        tick();
        out_ready = (holdoff == 0);
        #1;
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(ed));
        chk("hold_id", 32'(out_id), 32'(g));
        chk("hold_ready", 32'(req_ready), 0);
        for (int h = 0; h < holdoff; h++) begin
            tick();
            if (h == holdoff - 1) out_ready = 1'b1;
            #1;
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'(ed));
            chk("bp_id", 32'(out_id), 32'(g));
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_done", 32'(done_cnt), 32'(done_exp));
        end
        tick();
        done_exp = (done_exp + 1) % 65536;
        out_ready = 1'b0;
        #1;
        chk("pop_valid", 32'(out_valid), 0);
        chk("pop_busy", 32'(busy), 0);
        chk("pop_done", 32'(done_cnt), 32'(done_exp));
    endtask

    initial begin
        int g;
        // Reset values, idle for 5 cycles.
        do_reset('0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_valid", 32'(out_valid), 0);
            chk("idle_data", 32'(out_data), 0);
            chk("idle_id", 32'(out_id), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_ready", 32'(req_ready), 0);
            chk("idle_done", 32'(done_cnt), 0);
        end

        // Single request and arithmetic corners.
        set_req(2, 16'h1000, 1'b0);
        txn(4'b0100, 0, 1'b0, 0);
        chk("c_0201", 32'(out_data), 32'h0201);
        chk("c_id2", 32'(out_id), 2);
        chk("c_done1", 32'(done_cnt), 1);
        set_req(3, 16'h1000, 1'b1);
        txn(4'b1000, 0, 1'b0, 0);
        chk("c_0008", 32'(out_data), 32'h0008);
        set_req(0, 16'h8000, 1'b0);
        txn(4'b0001, 0, 1'b0, 0);
        chk("c_0ff8", 32'(out_data), 32'h0FF8);
        set_req(1, 16'hFFFF, 1'b1);
        txn(4'b0010, 0, 1'b0, 0);
        chk("c_ffff", 32'(out_data), 32'hFFFF);

        // Fairness: all requesters valid from reset.
        for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 1'($urandom));
        do_reset(4'hF);
        for (int i = 0; i < 5; i++) begin
            txn(4'hF, 0, 1'b1, 3);
            chk("fair_id", 32'(out_id), 32'(i % N));
        end

        // Backpressure for 6 cycles, then the next grant follows at once.
        txn(4'hF, 6, 1'b0, 0);
        txn(4'hF, 0, 1'b0, 0);

        // Reset while holding a result.
        req_valid = 4'hF;
        #1;
        g = exp_grant(4'hF, ptr);
        chk("mid_grant", 32'(req_ready), 32'(1 << g));
        tick();
        tick();
        chk("mid_hold", 32'(out_valid), 1);
        rstn = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_done", 32'(done_cnt), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        rstn = 1'b1;
        #1;
        ptr = 0;
        done_exp = 0;
        last_acc = -1;
        chk("mid_after_grant0", 32'(req_ready), 32'h1);
        txn(4'hF, 0, 1'b0, 0);
        chk("mid_after_id0", 32'(out_id), 0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 1'($urandom));
            txn(4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'($urandom), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
